// File: rtl/mem_block_mover.sv
// Block mover for a single-port bank: copies LEN words from src to dst and
// adds a signed, saturating offset to each word, two cycles per word.
module mem_block_mover #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] offset,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic              mem_wr_chip_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);

  // Returns {clamped, result}; overflow shows as disagreeing top two sum bits.
  function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      if (sum[DATA_W]) begin
        sat_add = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, sum[DATA_W-1:0]};
    end
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   offset_q, offset_d;
  logic                desc_q, desc_d;
  logic                sat_q, sat_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                busy_q, done_q, rd_en_q, wr_en_q, chip_en_q;

  logic [ADDR_W:0]     src_end_s;
  logic                start_desc_s;
  logic [ADDR_W-1:0]   src_last_s, dst_last_s;
  logic [DATA_W:0]     sat_s;

  // Direction decision uses the unwrapped end address so a wrapping source
  // region is never mistaken for an overlapping forward move.
  assign src_end_s    = {1'b0, src_base} + len;
  assign start_desc_s = (dst_base > src_base) && ({1'b0, dst_base} < src_end_s);
  assign src_last_s   = src_base + len[ADDR_W-1:0] - A_ONE;
  assign dst_last_s   = dst_base + len[ADDR_W-1:0] - A_ONE;
  assign sat_s        = sat_add(mem_rd_data, offset_q);

  // Next-state, pointer stepping and sticky saturation tracking
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    desc_d    = desc_q;
    sat_d     = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          offset_d  = offset;
          cnt_d     = len;
          sat_d     = 1'b0;
          desc_d    = start_desc_s;
          src_ptr_d = start_desc_s ? src_last_s : src_base;
          dst_ptr_d = start_desc_s ? dst_last_s : dst_base;
          state_d   = (len == CNT_ZERO) ? S_FIN : S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_WR;
      end
      S_WR: begin
        src_ptr_d = desc_q ? (src_ptr_q - A_ONE) : (src_ptr_q + A_ONE);
        dst_ptr_d = desc_q ? (dst_ptr_q - A_ONE) : (dst_ptr_q + A_ONE);
        cnt_d     = cnt_q - CNT_ONE;
        sat_d     = sat_q | sat_s[DATA_W];
        state_d   = (cnt_q == CNT_ONE) ? S_FIN : S_RD;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rd_addr_d = (state_d == S_RD) ? src_ptr_d : rd_addr_q;
    wr_addr_d = (state_d == S_WR) ? dst_ptr_d : wr_addr_q;
  end

  // State, datapath and registered bank controls decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_ptr_q <= {ADDR_W{1'b0}};
      dst_ptr_q <= {ADDR_W{1'b0}};
      cnt_q     <= {(ADDR_W+1){1'b0}};
      offset_q  <= {DATA_W{1'b0}};
      desc_q    <= 1'b0;
      sat_q     <= 1'b0;
      rd_addr_q <= {ADDR_W{1'b0}};
      wr_addr_q <= {ADDR_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      chip_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      desc_q    <= desc_d;
      sat_q     <= sat_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= (state_d == S_RD) || (state_d == S_WR);
      done_q    <= (state_d == S_FIN);
      rd_en_q   <= (state_d == S_RD);
      wr_en_q   <= (state_d == S_WR);
      chip_en_q <= (state_d == S_RD) || (state_d == S_WR);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign sat_flag       = sat_q;
  assign mem_rd_en      = rd_en_q;
  assign mem_rd_addr    = rd_addr_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_wr_chip_en = chip_en_q;
  assign mem_wr_addr    = wr_addr_q;
  assign mem_wr_data    = (state_q == S_WR) ? sat_s[DATA_W-1:0] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed and randomised checks of mem_block_mover against a behavioural
// bank model and a word-by-word reference copy.
module tb_mem_block_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  src_base, dst_base;
  logic [10:0] len;
  logic [15:0] offset;
  logic        busy, done, sat_flag;
  logic        mem_rd_en, mem_wr_en, mem_wr_chip_en;
  logic [9:0]  mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_rd_data, mem_wr_data;

  logic [15:0] bank [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [15:0] bd_data;

  logic        cap_en, watch_en;
  logic [9:0]  rd_log [0:7];
  int          rd_n, en_cnt, done_cnt, viol_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_block_mover #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_base(src_base), .dst_base(dst_base), .len(len), .offset(offset),
    .busy(busy), .done(done), .sat_flag(sat_flag),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_chip_en(mem_wr_chip_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  // Bank model: registered read, write on enable, plus a backdoor preload port
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= bank[mem_rd_addr];
    if (mem_wr_en && mem_wr_chip_en) bank[mem_wr_addr] <= mem_wr_data;
    if (bd_we) bank[bd_addr] <= bd_data;
  end

  // Observers: read-address log, enable activity, done pulses
  always @(posedge clk) begin
    if (!cap_en) rd_n <= 0;
    else if (mem_rd_en && rd_n < 8) begin
      rd_log[rd_n] <= mem_rd_addr;
      rd_n <= rd_n + 1;
    end
    if (!watch_en) begin
      en_cnt <= 0;
      done_cnt <= 0;
    end else begin
      if (mem_rd_en || mem_wr_en || mem_wr_chip_en) en_cnt <= en_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // Bank protocol invariants
  always @(negedge clk) begin
    if (rst_n) begin
      if ((mem_rd_en && mem_wr_en) ||
          ((mem_rd_en || mem_wr_en) && !mem_wr_chip_en) ||
          (!busy && mem_wr_chip_en))
        viol_cnt <= viol_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [15:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v; ref_mem[a] = v;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  function automatic logic [16:0] ref_sat(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else return {1'b0, s[15:0]};
  endfunction

  task automatic ref_move(input int s, input int d, input int l, input logic [15:0] o,
                          output logic exp_sat);
    bit desc;
    int sp, dp;
    logic [16:0] r;
    desc = (d > s) && (d < s + l);
    sp = desc ? (s + l - 1) % 1024 : s;
    dp = desc ? (d + l - 1) % 1024 : d;
    exp_sat = 1'b0;
    for (int i = 0; i < l; i++) begin
      r = ref_sat(ref_mem[sp], o);
      ref_mem[dp] = r[15:0];
      if (r[16]) exp_sat = 1'b1;
      sp = desc ? (sp + 1023) % 1024 : (sp + 1) % 1024;
      dp = desc ? (dp + 1023) % 1024 : (dp + 1) % 1024;
    end
  endtask

  // Cycle counts are relative to the edge that samples start (cycle k).
  task automatic run_xfer(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                          input logic [15:0] o, input bit inject,
                          output int done_cyc, output int busy_cyc);
    int c;
    @(negedge clk);
    done_cyc = -1; busy_cyc = 0; c = 0;
    src_base = s; dst_base = d; len = l; offset = o; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (done_cyc < 0 && c < 3000) begin
      @(negedge clk);
      c++;
      if (busy) busy_cyc++;
      if (done) done_cyc = c;
      if (inject && c == 2) begin
        start = 1'b1; src_base = 10'd500; dst_base = 10'd600; len = 11'd1; offset = 16'h0005;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int dc, bc, diffs, s, d, l;
    logic [15:0] o;
    logic exp_sat;
    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0; offset = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; cap_en = 1'b0; watch_en = 1'b0;
    viol_cnt = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {busy, done, sat_flag, mem_rd_en, mem_wr_en, mem_wr_chip_en}, 32'h0);
    check_eq("rst_addr", {mem_rd_addr, mem_wr_addr}, 32'h0);
    check_eq("rst_wdata", mem_wr_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy
    for (int i = 0; i < 4; i++) poke(10'(i), 16'(i + 1));
    run_xfer(10'd0, 10'd16, 11'd4, 16'h0000, 1'b0, dc, bc);
    check_eq("basic_done_cyc", dc, 9);
    check_eq("basic_busy_cyc", bc, 8);
    for (int i = 0; i < 4; i++) check_eq("basic_data", bank[16 + i], i + 1);
    check_eq("basic_sat", sat_flag, 0);

    // Offset and saturation
    poke(10'd0, 16'h7FF0); poke(10'd1, 16'h8005); poke(10'd2, 16'h0005);
    run_xfer(10'd0, 10'd8, 11'd3, 16'h0020, 1'b0, dc, bc);
    check_eq("sat_pos", bank[8], 32'h7FFF);
    check_eq("sat_mid", bank[9], 32'h8025);
    check_eq("sat_small", bank[10], 32'h0025);
    check_eq("sat_flag1", sat_flag, 1);
    run_xfer(10'd1, 10'd12, 11'd1, 16'hFF00, 1'b0, dc, bc);
    check_eq("sat_neg", bank[12], 32'h8000);
    check_eq("sat_flag2", sat_flag, 1);

    // Overlap: forward move must go descending, backward ascending
    for (int i = 0; i < 4; i++) poke(10'(i), 16'(10 + i));
    run_xfer(10'd0, 10'd2, 11'd4, 16'h0000, 1'b0, dc, bc);
    for (int i = 0; i < 4; i++) check_eq("ovl_fwd", bank[2 + i], 10 + i);
    check_eq("ovl_sat_clr", sat_flag, 0);
    run_xfer(10'd2, 10'd0, 11'd4, 16'h0000, 1'b0, dc, bc);
    for (int i = 0; i < 4; i++) check_eq("ovl_back", bank[i], 10 + i);

    // Source wrap
    poke(10'd1022, 16'h0111); poke(10'd1023, 16'h0222); poke(10'd0, 16'h0333); poke(10'd1, 16'h0444);
    cap_en = 1'b1;
    run_xfer(10'd1022, 10'd100, 11'd4, 16'h0000, 1'b0, dc, bc);
    cap_en = 1'b0;
    check_eq("wrap_nrd", rd_n, 4);
    check_eq("wrap_rd0", rd_log[0], 1022);
    check_eq("wrap_rd1", rd_log[1], 1023);
    check_eq("wrap_rd2", rd_log[2], 0);
    check_eq("wrap_rd3", rd_log[3], 1);
    check_eq("wrap_data", bank[102], 32'h0333);

    // Zero length
    watch_en = 1'b1;
    run_xfer(10'd5, 10'd6, 11'd0, 16'h0001, 1'b0, dc, bc);
    check_eq("len0_done_cyc", dc, 1);
    check_eq("len0_busy", bc, 0);
    repeat (2) @(negedge clk);
    check_eq("len0_enables", en_cnt, 0);
    watch_en = 1'b0;

    // Start while busy is ignored
    poke(10'd600, 16'h7777);
    run_xfer(10'd0, 10'd200, 11'd4, 16'h0000, 1'b1, dc, bc);
    check_eq("ign_done_cyc", dc, 9);
    for (int i = 0; i < 4; i++) check_eq("ign_data", bank[200 + i], 32'(ref_mem[i]));
    repeat (3) @(negedge clk);
    check_eq("ign_idle", busy, 0);
    check_eq("ign_dst", bank[600], 32'h7777);

    // Reset mid-transfer: two words land, third does not, no done
    for (int i = 0; i < 8; i++) poke(10'(i), 16'(16'h0100 + i));
    for (int i = 0; i < 3; i++) poke(10'(300 + i), 16'h5555);
    watch_en = 1'b1;
    src_base = 10'd0; dst_base = 10'd300; len = 11'd8; offset = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", {busy, done, sat_flag, mem_rd_en, mem_wr_en, mem_wr_chip_en}, 32'h0);
    check_eq("mid_rst_bus", {mem_rd_addr, mem_wr_addr, 16'(mem_wr_data)}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("mid_rst_w0", bank[300], 32'h0100);
    check_eq("mid_rst_w1", bank[301], 32'h0101);
    check_eq("mid_rst_w2", bank[302], 32'h5555);
    check_eq("mid_rst_nodone", done_cnt, 0);
    watch_en = 1'b0;

    // Random soak against the reference copy
    for (int a = 0; a < 1024; a++) poke(10'(a), 16'($urandom));
    for (int t = 0; t < 200; t++) begin
      s = $urandom_range(0, 1023);
      d = $urandom_range(0, 1023);
      l = $urandom_range(0, 24);
      o = 16'($urandom);
      if (t == 0) begin
        l = 1024;
        d = s;
      end else if (t % 4 == 0) begin
        d = (s + $urandom_range(1, 8)) % 1024;
      end
      ref_move(s, d, l, o, exp_sat);
      run_xfer(10'(s), 10'(d), 11'(l), o, 1'b0, dc, bc);
      check_eq("soak_done_cyc", dc, 2 * l + 1);
      check_eq("soak_sat", sat_flag, exp_sat);
      diffs = 0;
      for (int a = 0; a < 1024; a++) if (bank[a] !== ref_mem[a]) diffs++;
      check_eq("soak_bank", diffs, 0);
    end
    check_eq("protocol", viol_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
